serial_subtractor: RTL

- Multi-cycle, parametrised N-bit subtractor computing diff = a - b - borrow_in.
- Processes BITS_PER_CYCLE bits per clock, LSB first, through a rippled chain of full-subtractor slices.
- Trades latency for area; the next-generation arithmetic cell after the single-bit half subtractor.
- Used wherever a wide subtract is needed but a full-width combinational borrow chain is too slow or too large.

---
 rtl/serial_subtractor_pkg.sv | 25 ++
 rtl/serial_subtractor_sub_chunk.sv | 27 ++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
// The bit-serial datapath lives in serial_subtractor; the slice chain in sub_chunk.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int calc_steps(input int w, input int bpc);
      return w / bpc;
   endfunction

   function automatic int calc_cnt_w(input int w, input int bpc);
      int s;
      s = w / bpc;
      return (s <= 1) ? 1 : $clog2(s);
   endfunction

   function automatic bit bpc_divides(input int w, input int bpc);
      return (bpc > 0) && (w % bpc == 0);
   endfunction

endpackage

// File: rtl/serial_subtractor_sub_chunk.sv
// Combinational ripple of full-subtractor slices, one chunk wide.
// Borrow enters at bit 0 and leaves from the top slice.
module serial_subtractor_sub_chunk #(
   parameter int BPC = 1
) (
   input  logic [BPC-1:0] a_chunk,
   input  logic [BPC-1:0] b_chunk,
   input  logic           bi,
   output logic [BPC-1:0] d_chunk,
   output logic           bo
);

   logic [BPC:0] brw;

   always_comb begin
      brw     = '0;
      d_chunk = '0;
      brw[0]  = bi;
      for (int i = 0; i < BPC; i++) begin
         d_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ brw[i];
         brw[i+1]   = (~a_chunk[i] & b_chunk[i])
                    | (~(a_chunk[i] ^ b_chunk[i]) & brw[i]);
      end
      bo = brw[BPC];
   end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borrow_in, BITS_PER_CYCLE bits per clock, LSB first.
// Results are published only on the final RUN edge and held until the next one.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int BPC   = BITS_PER_CYCLE;
   localparam int STEPS = calc_steps(WIDTH, BPC);
   localparam int CW    = calc_cnt_w(WIDTH, BPC);

   if (!bpc_divides(WIDTH, BPC) || WIDTH < 2) begin : g_bad_cfg
      $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] dw_q, dw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             sa_q, sa_d, sb_q, sb_d;
   logic             bo_q, bo_d, ov_q, ov_d;
   logic [BPC-1:0]   d_chunk;
   logic             chunk_bo;

   serial_subtractor_sub_chunk #(.BPC(BPC)) u_chunk (
      .a_chunk (a_q[BPC-1:0]),
      .b_chunk (b_q[BPC-1:0]),
      .bi      (brw_q),
      .d_chunk (d_chunk),
      .bo      (chunk_bo)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      dw_d    = dw_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bo_d    = bo_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = borrow_in;
               sa_d    = a[WIDTH-1];
               sb_d    = b[WIDTH-1];
               dw_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            dw_d[int'(cnt_q)*BPC +: BPC] = d_chunk;
            a_d   = a_q >> BPC;
            b_d   = b_q >> BPC;
            brw_d = chunk_bo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS-1)) begin
               // dw_d already holds the final chunk here
               diff_d  = dw_d;
               bo_d    = chunk_bo;
               ov_d    = (sa_q ^ sb_q) & (dw_d[WIDTH-1] ^ sa_q);
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         dw_q    <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bo_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dw_q    <= dw_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bo_q    <= bo_d;
         ov_q    <= ov_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = bo_q;
   assign overflow   = ov_q;

endmodule
